rr_mux_arb: RTL and testbench

- N-to-1 streaming multiplexer with round-robin arbitration; the transmit-side counterpart of the 1:N demux path.
- Collects words from NCH independent valid/ready input channels and serialises them onto a single output stream.
- Each output word is tagged with its source channel index, so a downstream demux can route it back out.
- Single registered output stage gives one cycle of latency and full throughput.

---
 rtl/rr_mux_arb_if.sv | 26 ++
 rtl/rr_mux_arb.sv | 69 ++++++
 tb/tb_rr_mux_arb.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/rr_mux_arb_if.sv
// Stream bundle for the round-robin N:1 mux: NCH valid/ready input channels
// and one tagged, registered output stream.
interface rr_mux_arb_if #(
  parameter int NCH = 4,
  parameter int W   = 8,
  parameter int SW  = $clog2(NCH)
);
  logic [NCH*W-1:0] in_data;
  logic [NCH-1:0]   in_valid;
  logic [NCH-1:0]   in_ready;
  logic [W-1:0]     out_data;
  logic [SW-1:0]    out_sel;
  logic             out_valid;
  logic             out_ready;

  // master drives the channel inputs and consumes the output stream
  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_sel, out_valid
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_sel, out_valid
  );
endinterface

// File: rtl/rr_mux_arb.sv
// N:1 round-robin streaming mux: one registered output stage, one word per
// cycle, each word tagged with the index of the channel it came from.
module rr_mux_arb #(
  parameter int NCH = 4,
  parameter int W   = 8
) (
  input logic        clk,
  input logic        rst,
  rr_mux_arb_if.slave bus
);
  localparam int SW = $clog2(NCH);

  logic [SW-1:0] rr_ptr;
  logic [SW-1:0] gnt;
  logic [SW-1:0] cand;
  logic          any_vld;
  logic          load;
  logic [NCH-1:0] rdy;
  logic [W-1:0]   gnt_data;

  logic [W-1:0]  out_data_p0;
  logic [SW-1:0] out_sel_p0;
  logic          vld_p0;

  assign any_vld = |bus.in_valid;
  assign load    = !vld_p0 || bus.out_ready;

  // Scan from farthest to nearest offset so the nearest valid channel after
  // rr_ptr is the one left in gnt; offset NCH wraps back to rr_ptr itself.
  always_comb begin
    gnt  = rr_ptr;
    cand = '0;
    for (int k = NCH; k >= 1; k--) begin
      cand = SW'((int'(rr_ptr) + k) % NCH);
      if (bus.in_valid[cand]) gnt = cand;
    end
  end

  always_comb begin
    rdy = '0;
    if (!rst && load && any_vld) rdy[gnt] = 1'b1;
  end

  assign gnt_data     = bus.in_data[gnt*W +: W];
  assign bus.in_ready = rdy;

  // Stage p0: output register
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p0      <= 1'b0;
      out_data_p0 <= '0;
      out_sel_p0  <= '0;
      rr_ptr      <= SW'(NCH - 1);
    end else if (load) begin
      if (any_vld) begin
        vld_p0      <= 1'b1;
        out_data_p0 <= gnt_data;
        out_sel_p0  <= gnt;
        rr_ptr      <= gnt;
      end else begin
        vld_p0 <= 1'b0;
      end
    end
  end

  assign bus.out_data  = out_data_p0;
  assign bus.out_sel   = out_sel_p0;
  assign bus.out_valid = vld_p0;
endmodule

// File: tb/tb_rr_mux_arb.sv
// Bench for rr_mux_arb: directed scenarios followed by constrained-random
// traffic, all checked against a transaction-level reference model.
module tb_rr_mux_arb;
  localparam int NCH = 4;
  localparam int W   = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rr_mux_arb_if #(.NCH(NCH), .W(W)) bus ();

  rr_mux_arb #(.NCH(NCH), .W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // reference model state
  int             last_g;
  bit             m_vld;
  logic [W-1:0]   m_data;
  int             m_sel;
  logic [NCH-1:0] e_rdy;
  logic [W-1:0]   dch [NCH];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Winner = valid channel at the smallest circular distance after last_g.
  function automatic int pick(input logic [NCH-1:0] v);
    int best  = -1;
    int bestd = NCH;
    for (int i = 0; i < NCH; i++) begin
      int d;
      d = (i - last_g - 1 + 2 * NCH) % NCH;
      if (v[i] && d < bestd) begin
        bestd = d;
        best  = i;
      end
    end
    return best;
  endfunction

  task automatic step(input logic r, input logic [NCH-1:0] v, input logic ordy);
    int g;
    bit load;
    rst           = r;
    bus.in_valid  = v;
    bus.out_ready = ordy;
    for (int i = 0; i < NCH; i++) bus.in_data[i*W +: W] = dch[i];
    #1;
    load  = !m_vld || ordy;
    g     = pick(v);
    e_rdy = '0;
    if (!r && load && g >= 0) e_rdy[g] = 1'b1;
    chk("in_ready", 32'(bus.in_ready), 32'(e_rdy));
    @(posedge clk);
    if (r) begin
      m_vld  = 1'b0;
      m_data = '0;
      m_sel  = 0;
      last_g = NCH - 1;
    end else if (load) begin
      if (g >= 0) begin
        m_vld  = 1'b1;
        m_data = dch[g];
        m_sel  = g;
        last_g = g;
      end else begin
        m_vld = 1'b0;
      end
    end
    #1;
    chk("out_valid", 32'(bus.out_valid), 32'(m_vld));
    chk("out_sel",   32'(bus.out_sel),   32'(m_sel));
    chk("out_data",  32'(bus.out_data),  32'(m_data));
  endtask

  initial begin
    logic [NCH-1:0] v;
    m_vld  = 1'b0;
    m_data = '0;
    m_sel  = 0;
    last_g = NCH - 1;
    e_rdy  = '0;
    for (int i = 0; i < NCH; i++) dch[i] = 8'hA0 + 8'(i);

    // reset with every channel requesting
    step(1'b1, 4'b1111, 1'b1);
    step(1'b1, 4'b1111, 1'b1);
    chk("rst_rdy",   32'(bus.in_ready),  32'h0);
    chk("rst_valid", 32'(bus.out_valid), 32'h0);

    // full round-robin: grants 0,1,2,3,0
    for (int k = 0; k < 5; k++) begin
      step(1'b0, 4'b1111, 1'b1);
      chk("rr_sel",  32'(bus.out_sel),  32'(k % NCH));
      chk("rr_data", 32'(bus.out_data), 32'(8'hA0 + (k % NCH)));
    end

    // backpressure holding A1, then drain and load ch2 on the same edge
    step(1'b1, 4'b1111, 1'b1);
    step(1'b0, 4'b1111, 1'b1);
    step(1'b0, 4'b1111, 1'b1);
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 4'b1111, 1'b0);
      chk("bp_data", 32'(bus.out_data), 32'h0A1);
      chk("bp_rdy",  32'(bus.in_ready), 32'h0);
    end
    step(1'b0, 4'b1111, 1'b1);
    chk("bp_next", 32'(bus.out_sel), 32'd2);

    // sparse with wrap, then a single requester
    step(1'b1, 4'b0000, 1'b1);
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 4'b1001, 1'b1);
      chk("wrap_sel", 32'(bus.out_sel), (k == 1) ? 32'd3 : 32'd0);
    end
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 4'b0100, 1'b1);
      chk("single_sel", 32'(bus.out_sel), 32'd2);
    end

    // idle drain of one word
    dch[1] = 8'h5C;
    step(1'b0, 4'b0010, 1'b1);
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 4'b0000, 1'b1);
      chk("drain_data", 32'(bus.out_data), 32'h05C);
    end
    dch[1] = 8'hA1;

    // reset while a word is held under backpressure
    step(1'b0, 4'b1111, 1'b0);
    step(1'b0, 4'b1111, 1'b0);
    step(1'b1, 4'b1111, 1'b0);
    step(1'b0, 4'b1111, 1'b1);
    chk("mid_rst_sel", 32'(bus.out_sel), 32'd0);

    // randomized traffic; sources hold valid and data until accepted
    v = '0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NCH; i++) begin
        if (!v[i] || e_rdy[i]) begin
          v[i]   = ($urandom_range(0, 2) != 0);
          dch[i] = 8'($urandom);
        end
      end
      step(($urandom_range(0, 49) == 0), v, ($urandom_range(0, 3) != 0));
      if (rst) v = '0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
